ibex_mem_arbiter: RTL and testbench
===================================

Name: ibex_mem_arbiter

Overview:
Shares one req/gnt/rvalid memory port between the core's instruction-fetch and data interfaces. Used in single-port-memory integrations of the core and its tracing top level. Arbitrates per request (round-robin, locked while ungranted) and tracks outstanding transactions in order. Routes each response back to the requester that issued it.

Parameters:
MaxOutstanding, 2, depth of the in-order owner FIFO (max in-flight granted requests); legal 1..8
ResetGrantData, 1'b1, initial last-granted owner; 1 means instruction side wins the first tie

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
instr_req_i  in  1  fetch request
instr_gnt_o  out  1  fetch grant
instr_rvalid_o  out  1  fetch response valid
instr_addr_i  in  32  fetch address
instr_rdata_o  out  32  fetch read data
instr_err_o  out  1  fetch bus error
data_req_i  in  1  LSU request
data_gnt_o  out  1  LSU grant
data_rvalid_o  out  1  LSU response valid
data_we_i  in  1  LSU write enable
data_be_i  in  4  LSU byte enables
data_addr_i  in  32  LSU address
data_wdata_i  in  32  LSU write data
data_rdata_o  out  32  LSU read data
data_err_o  out  1  LSU bus error
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory grant
mem_rvalid_i  in  1  memory response valid
mem_we_o  out  1  memory write enable
mem_be_o  out  4  memory byte enables
mem_addr_o  out  32  memory address
mem_wdata_o  out  32  memory write data
mem_rdata_i  in  32  memory read data
mem_err_i  in  1  memory bus error

Behaviour:
- Clock clk_i, reset rst_ni asynchronous active-low; all state resets asynchronously.
- State: owner FIFO (MaxOutstanding x 1 bit, 0=instr, 1=data), count, lock_q, lock_owner_q, last_q.
- Reset values: FIFO empty, count=0, lock_q=0, last_q=ResetGrantData. All outputs 0 during reset: gnt, rvalid, mem_req, we, be, addr, wdata, rdata, err.
- Request path is combinational, zero cycles. mem_req_o = selected req & ~full.
- Selection: if lock_q, select lock_owner_q. Else if only one side requests, select that side. Else if both request, select ~last_q.
- Lock: mem_req_o=1 with mem_gnt_i=0 sets lock_q and lock_owner_q=selected. Any grant clears lock_q. Keeps address/attributes stable until grant.
- Grant: grant goes to the selected side = mem_req_o & mem_gnt_i. The unselected side's gnt_o is 0.
- On grant: push owner, last_q=owner.
- Instr-selected attributes: mem_we_o=0, mem_be_o=4'b1111, mem_wdata_o=0. Data-selected: pass-through.
- Full (count==MaxOutstanding): mem_req_o=0 and both gnts 0, even if a pop occurs the same cycle. No push-on-pop bypass.
- Response path is combinational, zero cycles. mem_rvalid_i with count>0 pops the head and drives the head owner's rvalid_o, rdata_o and err_o for that cycle. The other side's rvalid_o=0.
- rdata_o/err_o on both sides mirror mem_rdata_i/mem_err_i. They are only meaningful with rvalid_o.
- Simultaneous push and pop: count unchanged, FIFO order preserved.
- mem_rvalid_i with empty FIFO: response dropped, no rvalid_o, count stays 0. Simulation assertion fires.
- A requester dropping req while locked is a protocol violation (assertion). The lock still holds until the next grant.
- Reset mid-operation: in-flight ownership is lost. Responses arriving after reset are dropped as above.
- count arithmetic: $clog2(MaxOutstanding+1) bits, never wraps (assertions on overflow/underflow). FIFO pointers wrap modulo MaxOutstanding.

Optional Feature:
IBEX_MEM_ARB_PERF_EN
- Defined: adds outputs instr_stall_cnt_o[31:0] and data_stall_cnt_o[31:0].
- Each counter increments every cycle its req_i=1 and gnt_o=0, saturating at 32'hFFFF_FFFF. Reset 0.
- Undefined: ports and counters are absent; no behavioural difference otherwise.

Test Plan:
- Both req every cycle, mem_gnt_i=1, rvalid one cycle later, last_q reset=1 -> grants alternate instr, data, instr, data. Each rvalid goes to the matching side with the matching rdata.
- Data req alone, mem_gnt_i=0 for 3 cycles, instr req arrives in cycle 2 -> mem_addr_o holds data_addr_i all 4 cycles. Data granted in cycle 4, instr granted next.
- MaxOutstanding=2, two grants with no rvalid -> mem_req_o=0 on the third request. With rvalid and pending req in the same cycle, still no grant that cycle; grant the following cycle.
- Instr fetch granted -> mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0 regardless of data_* inputs.
- mem_rvalid_i pulse with empty FIFO, mem_err_i=1 -> no rvalid_o on either side, count stays 0.
- Assert rst_ni low with 2 outstanding, release, inject 2 rvalids -> both dropped. Next grant/response pair routes correctly. With IBEX_MEM_ARB_PERF_EN, a 5-cycle stalled data req gives data_stall_cnt_o=5.

Source files
------------

// File: rtl/ibex_mem_arbiter.sv
// rtl/ibex_mem_arbiter.sv - shares one req/gnt/rvalid memory port between ibex fetch and LSU
// Optional stall counters: define IBEX_MEM_ARB_PERF_EN.
module ibex_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter logic        ResetGrantData = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
`ifdef IBEX_MEM_ARB_PERF_EN
  ,
  output logic [31:0] instr_stall_cnt_o,
  output logic [31:0] data_stall_cnt_o
`endif
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

  logic [MaxOutstanding-1:0] fifo_q, fifo_d;
  logic [PtrW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]           count_q, count_d;
  logic                      lock_q, lock_d, lock_owner_q, lock_owner_d, last_q, last_d;

  logic sel_data, sel_req, full, push, pop, head_data;

  // Owner bit: 0 = instruction side, 1 = data side.
  always_comb begin
    sel_data = 1'b0;
    if (lock_q) begin
      sel_data = lock_owner_q;
    end else if (instr_req_i && data_req_i) begin
      sel_data = ~last_q;
    end else begin
      sel_data = data_req_i;
    end
  end

  assign sel_req   = sel_data ? data_req_i : instr_req_i;
  assign full      = (count_q == CntMax);
  assign mem_req_o = rst_ni & sel_req & ~full;
  assign push      = mem_req_o & mem_gnt_i;
  assign pop       = rst_ni & mem_rvalid_i & (count_q != '0);
  assign head_data = fifo_q[rptr_q];

  assign instr_gnt_o    = push & ~sel_data;
  assign data_gnt_o     = push & sel_data;
  assign instr_rvalid_o = pop & ~head_data;
  assign data_rvalid_o  = pop & head_data;
  assign instr_rdata_o  = rst_ni ? mem_rdata_i : '0;
  assign data_rdata_o   = rst_ni ? mem_rdata_i : '0;
  assign instr_err_o    = rst_ni & mem_err_i;
  assign data_err_o     = rst_ni & mem_err_i;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (rst_ni) begin
      if (sel_data) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  always_comb begin
    fifo_d       = fifo_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    last_d       = last_q;
    if (push) begin
      fifo_d[wptr_q] = sel_data;
      wptr_d         = (wptr_q == PtrLast) ? '0 : wptr_q + 1'b1;
      last_d         = sel_data;
      lock_d         = 1'b0;
    end else if (mem_req_o) begin
      // Pin the selection so the presented address stays stable until granted.
      lock_d       = 1'b1;
      lock_owner_d = sel_data;
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
      last_q       <= ResetGrantData;
    end else begin
      fifo_q       <= fifo_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      last_q       <= last_d;
    end
  end

`ifdef IBEX_MEM_ARB_PERF_EN
  logic [31:0] instr_stall_q, instr_stall_d, data_stall_q, data_stall_d;

  always_comb begin
    instr_stall_d = instr_stall_q;
    data_stall_d  = data_stall_q;
    if (instr_req_i && !instr_gnt_o && (instr_stall_q != 32'hFFFF_FFFF)) begin
      instr_stall_d = instr_stall_q + 32'd1;
    end
    if (data_req_i && !data_gnt_o && (data_stall_q != 32'hFFFF_FFFF)) begin
      data_stall_d = data_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_stall_q <= '0;
      data_stall_q  <= '0;
    end else begin
      instr_stall_q <= instr_stall_d;
      data_stall_q  <= data_stall_d;
    end
  end

  assign instr_stall_cnt_o = instr_stall_q;
  assign data_stall_cnt_o  = data_stall_q;
`endif

`ifndef SYNTHESIS
  a_rvalid_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> (count_q != '0))
    else $warning("ibex_mem_arbiter: response with no outstanding request dropped");
  a_locked_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> (lock_owner_q ? data_req_i : instr_req_i))
    else $warning("ibex_mem_arbiter: requester dropped req while locked");
  a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (count_q <= CntMax));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && full));
`endif

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// tb/tb_ibex_mem_arbiter.sv - directed and randomized bench for ibex_mem_arbiter
// Reference model: owner queue plus lock/last-granted bookkeeping.
module tb_ibex_mem_arbiter;

  localparam int MAXO = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o, mem_err_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
`ifdef IBEX_MEM_ARB_PERF_EN
  logic [31:0] instr_stall_cnt, data_stall_cnt;
`endif

  ibex_mem_arbiter #(.MaxOutstanding(MAXO), .ResetGrantData(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
`ifdef IBEX_MEM_ARB_PERF_EN
    , .instr_stall_cnt_o(instr_stall_cnt), .data_stall_cnt_o(data_stall_cnt)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  bit m_q[$];
  bit m_lock, m_lock_owner, m_last;
  bit i_held, d_held;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_lock = 1'b0;
    m_lock_owner = 1'b0;
    m_last = 1'b1;
    i_held = 1'b0;
    d_held = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    mem_err_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    instr_addr_i = 32'h1000_0004; data_addr_i = 32'h2000_0008;
    data_we_i = 1'b1; data_be_i = 4'h3; data_wdata_i = 32'h1234_5678;
    #1;
    check("rst_ctl", 64'({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, mem_req_o,
                           mem_we_o, mem_be_o, instr_err_o, data_err_o}), 64'd0);
    check("rst_addr_wdata", {mem_addr_o, mem_wdata_o}, 64'd0);
    check("rst_rdata", {instr_rdata_o, data_rdata_o}, 64'd0);
    repeat (2) @(negedge clk_i);
    instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_err_i = 1'b0;
    rst_ni = 1'b1;
    model_reset();
  endtask

  // One cycle: drive at negedge, check combinational outputs, advance the model.
  task automatic step(input bit ireq, input bit dreq, input bit mgnt, input bit mrv, input bit merr);
    bit sel, sreq, full, e_req, e_ig, e_dg, pop, head;
    @(negedge clk_i);
    instr_req_i = ireq;
    data_req_i  = dreq;
    if (!i_held) instr_addr_i = $urandom;
    if (!d_held) begin
      data_addr_i  = $urandom;
      data_we_i    = 1'($urandom);
      data_be_i    = 4'($urandom);
      data_wdata_i = $urandom;
    end
    mem_gnt_i    = mgnt;
    mem_rvalid_i = mrv;
    mem_err_i    = merr;
    mem_rdata_i  = $urandom;
    #1;
    if (m_lock)              sel = m_lock_owner;
    else if (ireq && dreq)   sel = ~m_last;
    else                     sel = dreq;
    sreq  = sel ? dreq : ireq;
    full  = (m_q.size() >= MAXO);
    e_req = sreq && !full;
    e_ig  = e_req && mgnt && !sel;
    e_dg  = e_req && mgnt && sel;
    pop   = mrv && (m_q.size() > 0);
    head  = pop ? m_q[0] : 1'b0;
    check("req_gnt", 64'({mem_req_o, instr_gnt_o, data_gnt_o}), 64'({e_req, e_ig, e_dg}));
    if (e_req) begin
      if (sel) begin
        check("attr_data", 64'({mem_we_o, mem_be_o, mem_addr_o}), 64'({data_we_i, data_be_i, data_addr_i}));
        check("wdata_data", 64'(mem_wdata_o), 64'(data_wdata_i));
      end else begin
        check("attr_instr", 64'({mem_we_o, mem_be_o, mem_addr_o}), 64'({1'b0, 4'hF, instr_addr_i}));
        check("wdata_instr", 64'(mem_wdata_o), 64'd0);
      end
    end
    check("rvalid", 64'({instr_rvalid_o, data_rvalid_o}), 64'({pop && !head, pop && head}));
    if (pop) begin
      if (head) check("rdata_data", 64'({data_rdata_o, data_err_o}), 64'({mem_rdata_i, merr}));
      else      check("rdata_instr", 64'({instr_rdata_o, instr_err_o}), 64'({mem_rdata_i, merr}));
      void'(m_q.pop_front());
    end
    if (e_ig || e_dg) begin
      m_q.push_back(sel);
      m_last = sel;
      m_lock = 1'b0;
    end else if (e_req) begin
      m_lock = 1'b1;
      m_lock_owner = sel;
    end
    i_held = ireq && !e_ig;
    d_held = dreq && !e_dg;
  endtask

  initial begin
    logic [31:0] a0;
    rst_ni = 1'b0;
    instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_err_i = 1'b0; mem_rdata_i = '0; instr_addr_i = '0; data_addr_i = '0;
    data_we_i = 1'b0; data_be_i = '0; data_wdata_i = '0;
    model_reset();
    do_reset();

    // Round-robin under constant contention, responses one cycle behind grants.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b1, k > 0, 1'b0);
      check("alt_gnt", 64'({instr_gnt_o, data_gnt_o}), (k % 2 == 0) ? 64'd2 : 64'd1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("alt_last_rsp", 64'({instr_rvalid_o, data_rvalid_o}), 64'd1);

    // Data stalled three cycles keeps the port locked despite a new instr request.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    a0 = data_addr_i;
    check("lock_addr", 64'(mem_addr_o), 64'(a0));
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("lock_addr", 64'(mem_addr_o), 64'(a0));
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("lock_addr", 64'(mem_addr_o), 64'(a0));
    check("lock_gnt_data", 64'({instr_gnt_o, data_gnt_o}), 64'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("lock_gnt_instr", 64'({instr_gnt_o, data_gnt_o}), 64'd2);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // FIFO full: no grant even when a response pops in the same cycle.
    repeat (2) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("full_no_req", 64'(mem_req_o), 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("full_pop_no_gnt", 64'({mem_req_o, instr_gnt_o}), 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("after_full_gnt", 64'(instr_gnt_o), 64'd1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Fetch attributes are fixed regardless of data-side inputs.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("fetch_attr", 64'({mem_we_o, mem_be_o, mem_wdata_o}), 64'({1'b0, 4'hF, 32'd0}));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Stray response with empty FIFO is dropped.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("stray_rsp", 64'({instr_rvalid_o, data_rvalid_o}), 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("after_stray_rsp", 64'({instr_rvalid_o, data_rvalid_o}), 64'd2);

    // Reset with two in flight; late responses are dropped.
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("post_rst_drop", 64'({instr_rvalid_o, data_rvalid_o}), 64'd0);
    end
`ifdef IBEX_MEM_ARB_PERF_EN
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i);
    #1;
    check("data_stall_cnt", 64'(data_stall_cnt), 64'd5);
    check("instr_stall_cnt", 64'(instr_stall_cnt), 64'd0);
`endif
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("post_rst_gnt", 64'({instr_gnt_o, data_gnt_o}), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("post_rst_rsp", 64'({instr_rvalid_o, data_rvalid_o}), 64'd1);

    // Randomized traffic with requesters holding req until granted.
    for (int k = 0; k < 500; k++) begin
      step(i_held ? 1'b1 : 1'($urandom),
           d_held ? 1'b1 : 1'($urandom),
           ($urandom % 4) != 0,
           (m_q.size() > 0) && (($urandom % 3) != 0),
           1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
